// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage data-memory access unit:
// datapath width, FSM encoding, byte-enable patterns and access-size decode.
package mem_access_unit_pkg;

    localparam int DP_WIDTH = 32;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_WAIT = 2'b01,
        MAU_DONE = 2'b10
    } mau_state_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } access_size_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte wins over half; neither flag means a full word.
    function automatic access_size_t decode_size(input logic mem_byte, input logic mem_half);
        if (mem_byte) return SIZE_BYTE;
        if (mem_half) return SIZE_HALF;
        return SIZE_WORD;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, replicated store data,
// load extract with sign/zero extension, and the natural-alignment check.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic                mem_byte,
    input  logic                mem_half,
    input  logic                mem_sign_ext,
    input  logic [1:0]          addr_low,
    input  logic [DP_WIDTH-1:0] store_data,
    input  logic [DP_WIDTH-1:0] rdata,
    output logic                aligned,
    output logic [3:0]          be,
    output logic [DP_WIDTH-1:0] wdata,
    output logic [DP_WIDTH-1:0] load_data
);

    access_size_t        size;
    logic [DP_WIDTH-1:0] shifted;

    assign size    = decode_size(mem_byte, mem_half);
    assign shifted = rdata >> {addr_low, 3'b000};

    // NOTE: every output is given a default before the case so no path can infer a latch.
    always_comb begin
        aligned   = 1'b1;
        be        = BE_WORD;
        wdata     = store_data;
        load_data = shifted;
        case (size)
            SIZE_BYTE: begin
                be        = BE_BYTE0 << addr_low;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{mem_sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                aligned   = ~addr_low[0];
                be        = addr_low[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{mem_sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                aligned = (addr_low == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: single-outstanding req/ack bus master
// with time-out, DONE-state result latch for held pipelines, and misalignment flags.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_MemRead,
    input  logic                MEM_MemWrite,
    input  logic                MEM_MemByte,
    input  logic                MEM_MemHalf,
    input  logic                MEM_MemSignExt,
    input  logic [31:0]         MEM_ALU_Result,
    input  logic [31:0]         MEM_ReadData2,
    input  logic                MEM_Kill,
    input  logic                MEM_Hold,
    output logic [31:0]         MEM_ReadData,
    output logic                MEM_Stall,
    output logic                MEM_AddrErrLoad,
    output logic                MEM_AddrErrStore,
    output logic                MEM_BusErr,
    output logic                DBus_Req,
    output logic                DBus_We,
    output logic [29:0]         DBus_Addr,
    output logic [3:0]          DBus_Be,
    output logic [31:0]         DBus_WData,
    input  logic [31:0]         DBus_RData,
    input  logic                DBus_Ack
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mau_state_t          state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DP_WIDTH-1:0] latch_data;
    logic                latch_err;
    logic                aligned, access, is_read, is_write, timeout, enter_done;
    logic [3:0]          lane_be;
    logic [DP_WIDTH-1:0] lane_wdata, load_data;

    mem_lane_align u_lane_align (
        .mem_byte     (MEM_MemByte),
        .mem_half     (MEM_MemHalf),
        .mem_sign_ext (MEM_MemSignExt),
        .addr_low     (MEM_ALU_Result[1:0]),
        .store_data   (MEM_ReadData2),
        .rdata        (DBus_RData),
        .aligned      (aligned),
        .be           (lane_be),
        .wdata        (lane_wdata),
        .load_data    (load_data)
    );

    // Read and write together is resolved as a read.
    assign is_read    = MEM_MemRead;
    assign is_write   = MEM_MemWrite & ~MEM_MemRead;
    assign access     = (MEM_MemRead | MEM_MemWrite) & aligned & ~MEM_Kill;
    assign timeout    = (state == MAU_WAIT) & ~DBus_Ack & (cnt == CNT_LAST);
    assign enter_done = (state != MAU_DONE) & (state_next == MAU_DONE);
    assign DBus_Addr  = MEM_ALU_Result[31:2];
    assign DBus_WData = lane_wdata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= MAU_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            latch_data <= '0;
            latch_err  <= 1'b0;
        end else begin
            if (state == MAU_IDLE && access && !DBus_Ack)
                cnt <= CNT_W'(1);
            else if (state == MAU_WAIT && !DBus_Ack && !timeout)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (enter_done) begin
                latch_data <= MEM_ReadData;
                latch_err  <= MEM_BusErr;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MAU_IDLE: if (access) state_next = DBus_Ack ? (MEM_Hold ? MAU_DONE : MAU_IDLE) : MAU_WAIT;
            MAU_WAIT: if (DBus_Ack || timeout) state_next = MEM_Hold ? MAU_DONE : MAU_IDLE;
            MAU_DONE: if (!MEM_Hold) state_next = MAU_IDLE;
            default:  state_next = MAU_IDLE;
        endcase
    end

    // All outputs are forced quiet while reset is held, whatever the inputs show.
    always_comb begin
        DBus_Req         = 1'b0;
        DBus_We          = 1'b0;
        DBus_Be          = BE_NONE;
        MEM_Stall        = 1'b0;
        MEM_ReadData     = '0;
        MEM_BusErr       = 1'b0;
        MEM_AddrErrLoad  = 1'b0;
        MEM_AddrErrStore = 1'b0;
        if (rst) begin
            case (state)
                MAU_IDLE: begin
                    DBus_Req  = access;
                    MEM_Stall = access & ~DBus_Ack;
                    if (access && DBus_Ack && is_read) MEM_ReadData = load_data;
                    if (!MEM_Kill && !aligned) begin
                        MEM_AddrErrLoad  = is_read;
                        MEM_AddrErrStore = is_write;
                    end
                end
                MAU_WAIT: begin
                    DBus_Req   = 1'b1;
                    MEM_Stall  = ~DBus_Ack & ~timeout;
                    MEM_BusErr = timeout;
                    if (DBus_Ack && is_read) MEM_ReadData = load_data;
                end
                MAU_DONE: begin
                    MEM_ReadData = latch_data;
                    MEM_BusErr   = latch_err;
                end
                default: ;
            endcase
            DBus_We = DBus_Req & is_write;
            DBus_Be = DBus_Req ? lane_be : BE_NONE;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever the unit completes or flags an error.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf, MEM_MemSignExt;
    logic [31:0] MEM_ALU_Result, MEM_ReadData2;
    logic        MEM_Kill, MEM_Hold;
    logic [31:0] MEM_ReadData;
    logic        MEM_Stall, MEM_AddrErrLoad, MEM_AddrErrStore, MEM_BusErr;
    logic        DBus_Req, DBus_We;
    logic [29:0] DBus_Addr;
    logic [3:0]  DBus_Be;
    logic [31:0] DBus_WData, DBus_RData;
    logic        DBus_Ack;

    mem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_MemRead      (MEM_MemRead),
        .MEM_MemWrite     (MEM_MemWrite),
        .MEM_MemByte      (MEM_MemByte),
        .MEM_MemHalf      (MEM_MemHalf),
        .MEM_MemSignExt   (MEM_MemSignExt),
        .MEM_ALU_Result   (MEM_ALU_Result),
        .MEM_ReadData2    (MEM_ReadData2),
        .MEM_Kill         (MEM_Kill),
        .MEM_Hold         (MEM_Hold),
        .MEM_ReadData     (MEM_ReadData),
        .MEM_Stall        (MEM_Stall),
        .MEM_AddrErrLoad  (MEM_AddrErrLoad),
        .MEM_AddrErrStore (MEM_AddrErrStore),
        .MEM_BusErr       (MEM_BusErr),
        .DBus_Req         (DBus_Req),
        .DBus_We          (DBus_We),
        .DBus_Addr        (DBus_Addr),
        .DBus_Be          (DBus_Be),
        .DBus_WData       (DBus_WData),
        .DBus_RData       (DBus_RData),
        .DBus_Ack         (DBus_Ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_addr_err;
        logic [31:0] read_data;
        logic        bus_err;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [29:0] addr;
        logic        err_load;
        logic        err_store;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the byte-lane rules.
    function automatic logic [31:0] model_load(input bit bt, input bit hf, input bit sx,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (bt) begin
            v = v % 256;
            if (sx && v >= 128) v = v - 256;
        end else if (hf) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input bit bt, input bit hf, input logic [31:0] addr);
        if (bt) return 4'(1 << (addr % 4));
        if (hf) return 4'(3 << (addr % 4));
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input bit bt, input bit hf, input logic [31:0] d);
        if (bt) return (d % 256) * 32'h0101_0101;
        if (hf) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && ((DBus_Req && !MEM_Stall) || MEM_AddrErrLoad || MEM_AddrErrStore)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(DBus_Req), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_addr_err) begin
                    check("addr_err_load",  32'(MEM_AddrErrLoad),  32'(mon_e.err_load));
                    check("addr_err_store", 32'(MEM_AddrErrStore), 32'(mon_e.err_store));
                    check("misaligned_req", 32'(DBus_Req),  32'd0);
                    check("misaligned_stall", 32'(MEM_Stall), 32'd0);
                end else begin
                    check("read_data", MEM_ReadData, mon_e.read_data);
                    check("bus_err",   32'(MEM_BusErr), 32'(mon_e.bus_err));
                    check("be",        32'(DBus_Be),    32'(mon_e.be));
                    check("we",        32'(DBus_We),    32'(mon_e.we));
                    check("addr",      32'(DBus_Addr),  32'(mon_e.addr));
                    if (mon_e.we) check("wdata", DBus_WData, mon_e.wdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        MEM_MemRead = 0; MEM_MemWrite = 0; MEM_MemByte = 0; MEM_MemHalf = 0;
        MEM_MemSignExt = 0; MEM_Kill = 0; MEM_Hold = 0; DBus_Ack = 0;
    endtask

    // waits < 0 means the bus never acknowledges; done_cycles > 0 holds the stage that long in DONE.
    task automatic run_access(input bit rd, input bit wr, input bit bt, input bit hf, input bit sx,
                              input bit kill, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int waits, input int done_cycles);
        bit          aligned, exp_err, fin;
        logic [31:0] exp_rd;
        exp_t        e;
        int          reqs, stalls, k;
        aligned = bt || (hf ? (addr % 2 == 0) : (addr % 4 == 0));
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemByte = bt; MEM_MemHalf = hf;
        MEM_MemSignExt = sx; MEM_Kill = kill; MEM_ALU_Result = addr; MEM_ReadData2 = wd;
        DBus_RData = rdata; MEM_Hold = (done_cycles > 0);
        if (kill) begin
            DBus_Ack = 1;
            @(negedge clk);
            check("kill_req", 32'(DBus_Req), 32'd0);
            check("kill_stall", 32'(MEM_Stall), 32'd0);
            check("kill_read_data", MEM_ReadData, 32'd0);
            check("kill_addr_err", 32'({MEM_AddrErrLoad, MEM_AddrErrStore}), 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            return;
        end
        if (!aligned) begin
            e = '{is_addr_err: 1, read_data: 0, bus_err: 0, we: 0, be: 0, wdata: 0, addr: 0,
                  err_load: rd, err_store: wr && !rd};
            sb_q.push_back(e);
            DBus_Ack = 0;
            @(negedge clk);
            @(posedge clk); #1;
            idle_inputs();
            return;
        end
        exp_err = (waits < 0);
        exp_rd  = (rd && !exp_err) ? model_load(bt, hf, sx, addr, rdata) : 32'd0;
        e = '{is_addr_err: 0, read_data: exp_rd, bus_err: exp_err, we: wr && !rd,
              be: model_be(bt, hf, addr), wdata: model_wdata(bt, hf, wd), addr: 30'(addr / 4),
              err_load: 0, err_store: 0};
        sb_q.push_back(e);
        reqs = 0; stalls = 0; fin = 0; k = 0;
        while (!fin && k < 50) begin
            DBus_Ack = (k == waits);
            @(negedge clk);
            reqs   += int'(DBus_Req);
            stalls += int'(MEM_Stall);
            if (!MEM_Stall) fin = 1;
            @(posedge clk); #1;
            k++;
        end
        check("req_cycles",   32'(reqs),   32'(exp_err ? T : waits + 1));
        check("stall_cycles", 32'(stalls), 32'(exp_err ? T - 1 : waits));
        for (int j = 0; j < done_cycles; j++) begin
            MEM_Hold = (j < done_cycles - 1);
            DBus_Ack = 1;
            @(negedge clk);
            check("done_req",       32'(DBus_Req),   32'd0);
            check("done_stall",     32'(MEM_Stall),  32'd0);
            check("done_read_data", MEM_ReadData,    exp_rd);
            check("done_bus_err",   32'(MEM_BusErr), 32'(exp_err));
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        check("after_req",       32'(DBus_Req), 32'd0);
        check("after_read_data", MEM_ReadData,  32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_in_wait();
        MEM_MemRead = 1; MEM_ALU_Result = 32'h0000_0040; DBus_RData = 32'h1111_2222;
        DBus_Ack = 0;
        repeat (2) begin
            @(negedge clk);
            check("rw_req_before", 32'(DBus_Req), 32'd1);
            @(posedge clk); #1;
        end
        rst = 0;
        @(negedge clk);
        check("rw_req_in_reset", 32'(DBus_Req), 32'd0);
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        DBus_Ack = 1;
        @(negedge clk);
        check("rw_late_ack_req",   32'(DBus_Req),   32'd0);
        check("rw_late_ack_data",  MEM_ReadData,    32'd0);
        check("rw_late_ack_stall", 32'(MEM_Stall),  32'd0);
        check("rw_late_ack_err",   32'(MEM_BusErr), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd, wr, bt, hf, sx, kill;
        logic [31:0] addr;
        int waits, done;

        rst = 0;
        idle_inputs();
        MEM_ReadData2 = 0; DBus_RData = 32'hFFFF_FFFF;
        MEM_MemRead = 1; MEM_ALU_Result = 32'h0000_1002; DBus_Ack = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req",   32'(DBus_Req),  32'd0);
        check("rst_we",    32'(DBus_We),   32'd0);
        check("rst_be",    32'(DBus_Be),   32'd0);
        check("rst_stall", 32'(MEM_Stall), 32'd0);
        check("rst_read_data", MEM_ReadData, 32'd0);
        check("rst_errs", 32'({MEM_BusErr, MEM_AddrErrLoad, MEM_AddrErrStore}), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;

        run_access(1, 0, 0, 0, 0, 0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0);   // lw zero-wait
        run_access(1, 0, 1, 0, 1, 0, 32'h0000_1003, 32'h0, 32'h8012_3456, 2, 0);   // lb
        run_access(1, 0, 1, 0, 0, 0, 32'h0000_1003, 32'h0, 32'h8012_3456, 2, 0);   // lbu
        run_access(0, 1, 0, 1, 0, 0, 32'h0000_2002, 32'h0000_1234, 32'h0, 1, 0);   // sh
        run_access(1, 0, 0, 0, 0, 0, 32'h0000_1002, 32'h0, 32'h0, 0, 0);           // lw misaligned
        run_access(0, 1, 0, 1, 0, 0, 32'h0000_2001, 32'h0, 32'h0, 0, 0);           // sh misaligned
        run_access(1, 0, 0, 0, 0, 0, 32'h0000_3000, 32'h0, 32'h1234_5678, -1, 0);  // time-out
        run_access(1, 0, 0, 1, 1, 0, 32'h0000_3002, 32'h0, 32'hABCD_0000, T-1, 0); // ack on last cycle
        run_access(1, 0, 0, 0, 0, 0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0, 3);   // hold in DONE
        run_access(1, 0, 0, 0, 0, 0, 32'h0000_4004, 32'h0, 32'h0BAD_0BAD, -1, 2);  // time-out held
        run_access(1, 0, 0, 0, 0, 1, 32'h0000_5002, 32'h0, 32'h7777_7777, 0, 0);   // killed, misaligned
        run_access(1, 1, 1, 0, 0, 0, 32'h0000_6001, 32'h55, 32'h0000_A500, 1, 0);  // read+write => read
        reset_in_wait();

        for (int i = 0; i < 40; i++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            bt   = ($urandom_range(0, 2) == 0);
            hf   = 1'($urandom_range(0, 1));
            sx   = 1'($urandom_range(0, 1));
            kill = ($urandom_range(0, 9) == 0);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (!bt && hf) addr = addr & 32'hFFFF_FFFE;
                else if (!bt)  addr = addr & 32'hFFFF_FFFC;
            end
            waits = $urandom_range(0, T);
            if (waits == T) waits = -1;
            done = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_access(rd, wr, bt, hf, sx, kill, addr, $urandom, $urandom, waits, done);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
